mem_stage: RTL and testbench

- Memory stage directly downstream of the execution stage.
- Each cycle it consumes one EX-stage result bundle: result_P, result_I, result_F, Wdata, plus the writeback controls carried down the pipe.
- Performs data-memory loads and stores over a req/ack handshake and stalls upstream stages while an access is outstanding.
- Presents a registered writeback bundle to the WB stage.

---
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; issues data-memory loads/stores over req/ack,
// stalls upstream during an access and emits a registered writeback bundle.
module mem_stage #(
    parameter int REG_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mem_ctl,
    input  logic             result_P,
    input  logic [31:0]      result_I,
    input  logic [31:0]      result_F,
    input  logic [31:0]      Wdata,
    input  logic             wb_en,
    input  logic [1:0]       wb_sel,
    input  logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ack,
    input  logic [31:0]      dmem_rdata,
    output logic             wb_valid_o,
    output logic             wb_en_o,
    output logic [REG_W-1:0] wb_dst_o,
    output logic [31:0]      wb_data_o,
    output logic             fault
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state, state_nx;
    logic [7:0]         cnt, cnt_nx;
    logic               req_nx, we_nx, valid_nx, en_nx, fault_nx;
    logic [31:0]        addr_nx, wdata_nx, data_nx;
    logic [REG_W-1:0]   dst_nx;
    logic               c_en, c_p, c_en_nx, c_p_nx;
    logic [1:0]         c_sel, c_sel_nx;
    logic [REG_W-1:0]   c_dst, c_dst_nx;
    logic [31:0]        c_f, c_f_nx;
    logic               is_mem;

    function automatic logic [31:0] sel_data(input logic [1:0] sel, input logic [31:0] i,
                                             input logic p, input logic [31:0] f);
        return sel == 2'd0 ? i : sel == 2'd1 ? {31'b0, p} : sel == 2'd2 ? f : 32'b0;
    endfunction

    assign stall  = (state == ACCESS);
    assign is_mem = (mem_ctl == 2'b01) || (mem_ctl == 2'b10);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = dmem_req;
        we_nx    = dmem_we;
        addr_nx  = dmem_addr;
        wdata_nx = dmem_wdata;
        valid_nx = 1'b0;
        en_nx    = wb_en_o;
        dst_nx   = wb_dst_o;
        data_nx  = wb_data_o;
        fault_nx = fault;
        c_en_nx  = c_en;
        c_p_nx   = c_p;
        c_sel_nx = c_sel;
        c_dst_nx = c_dst;
        c_f_nx   = c_f;
        if (state == IDLE) begin
            if (in_valid && !is_mem) begin
                valid_nx = 1'b1;
                en_nx    = wb_en;
                dst_nx   = wb_dst;
                data_nx  = sel_data(wb_sel, result_I, result_P, result_F);
            end else if (in_valid && result_I[1:0] != 2'b00) begin
                valid_nx = 1'b1;
                en_nx    = 1'b0;
                dst_nx   = wb_dst;
                data_nx  = 32'b0;
                fault_nx = 1'b1;
            end else if (in_valid) begin
                state_nx = ACCESS;
                cnt_nx   = 8'd0;
                req_nx   = 1'b1;
                we_nx    = (mem_ctl == 2'b10);
                addr_nx  = result_I;
                wdata_nx = Wdata;
                c_en_nx  = wb_en;
                c_p_nx   = result_P;
                c_sel_nx = wb_sel;
                c_dst_nx = wb_dst;
                c_f_nx   = result_F;
            end
        end else if (dmem_ack) begin
            state_nx = IDLE;
            req_nx   = 1'b0;
            valid_nx = 1'b1;
            dst_nx   = c_dst;
            en_nx    = dmem_we ? 1'b0 : c_en;
            data_nx  = dmem_we ? 32'b0 :
                       c_sel == 2'd3 ? dmem_rdata : sel_data(c_sel, dmem_addr, c_p, c_f);
        end else if (cnt == 8'(TIMEOUT - 1)) begin
            // Give up: retire the instruction as a non-writing fault.
            state_nx = IDLE;
            req_nx   = 1'b0;
            valid_nx = 1'b1;
            en_nx    = 1'b0;
            dst_nx   = c_dst;
            data_nx  = 32'b0;
            fault_nx = 1'b1;
        end else begin
            cnt_nx = cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid_o <= 1'b0;
            wb_en_o    <= 1'b0;
            wb_dst_o   <= '0;
            wb_data_o  <= '0;
            fault      <= 1'b0;
            c_en       <= 1'b0;
            c_p        <= 1'b0;
            c_sel      <= '0;
            c_dst      <= '0;
            c_f        <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dmem_req   <= req_nx;
            dmem_we    <= we_nx;
            dmem_addr  <= addr_nx;
            dmem_wdata <= wdata_nx;
            wb_valid_o <= valid_nx;
            wb_en_o    <= en_nx;
            wb_dst_o   <= dst_nx;
            wb_data_o  <= data_nx;
            fault      <= fault_nx;
            c_en       <= c_en_nx;
            c_p        <= c_p_nx;
            c_sel      <= c_sel_nx;
            c_dst      <= c_dst_nx;
            c_f        <= c_f_nx;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage with TIMEOUT=4.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, result_P, wb_en, dmem_ack;
    logic [1:0]  mem_ctl, wb_sel;
    logic [31:0] result_I, result_F, Wdata, dmem_rdata;
    logic [5:0]  wb_dst;
    logic        stall, dmem_req, dmem_we, wb_valid_o, wb_en_o, fault;
    logic [31:0] dmem_addr, dmem_wdata, wb_data_o;
    logic [5:0]  wb_dst_o;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_stage #(.REG_W(6), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_ctl(mem_ctl),
        .result_P(result_P), .result_I(result_I), .result_F(result_F), .Wdata(Wdata),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_dst(wb_dst), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid_o(wb_valid_o), .wb_en_o(wb_en_o), .wb_dst_o(wb_dst_o),
        .wb_data_o(wb_data_o), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bundle(input logic [1:0] ctl, input logic [31:0] ri, input logic [1:0] sel,
                          input logic [5:0] dst);
        in_valid = 1'b1;
        mem_ctl  = ctl;
        result_I = ri;
        wb_sel   = sel;
        wb_dst   = dst;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mem_ctl = 2'b00; result_P = 1'b1; result_I = '0;
        result_F = 32'h3F80_0000; Wdata = '0; wb_en = 1'b1; wb_sel = 2'd0; wb_dst = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        tick(); tick();
        chk("rst_valid", {31'b0, wb_valid_o}, 0);
        chk("rst_req", {31'b0, dmem_req}, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_data", wb_data_o, 0);
        rst_n = 1'b1;

        bundle(2'b00, 32'h12, 2'd0, 6'd1);
        tick();
        chk("alu0_valid", {31'b0, wb_valid_o}, 1);
        chk("alu0_data", wb_data_o, 32'h12);
        chk("alu0_stall", {31'b0, stall}, 0);
        wb_sel = 2'd1;
        tick();
        chk("alu1_data", wb_data_o, 32'h1);
        chk("alu1_stall", {31'b0, stall}, 0);
        wb_sel = 2'd2;
        tick();
        chk("alu2_data", wb_data_o, 32'h3F80_0000);
        chk("alu2_en", {31'b0, wb_en_o}, 1);
        chk("alu2_dst", {26'b0, wb_dst_o}, 1);
        bundle(2'b11, 32'h12, 2'd3, 6'd2);
        tick();
        chk("alu3_valid", {31'b0, wb_valid_o}, 1);
        chk("alu3_data", wb_data_o, 0);
        chk("alu3_req", {31'b0, dmem_req}, 0);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'b0, wb_valid_o}, 0);

        bundle(2'b01, 32'h100, 2'd3, 6'd5);
        tick();
        chk("ld_req0", {31'b0, dmem_req}, 1);
        chk("ld_we", {31'b0, dmem_we}, 0);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_stall0", {31'b0, stall}, 1);
        chk("ld_valid0", {31'b0, wb_valid_o}, 0);
        bundle(2'b00, 32'h77, 2'd0, 6'd7);
        tick();
        chk("ld_req1", {31'b0, dmem_req}, 1);
        chk("ld_stall1", {31'b0, stall}, 1);
        chk("ld_valid1", {31'b0, wb_valid_o}, 0);
        tick();
        chk("ld_req2", {31'b0, dmem_req}, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        chk("ld_stall_ack", {31'b0, stall}, 1);
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        chk("ld_wb_valid", {31'b0, wb_valid_o}, 1);
        chk("ld_wb_dst", {26'b0, wb_dst_o}, 5);
        chk("ld_wb_data", wb_data_o, 32'hDEAD_BEEF);
        chk("ld_wb_en", {31'b0, wb_en_o}, 1);
        chk("ld_req_drop", {31'b0, dmem_req}, 0);
        chk("ld_stall_drop", {31'b0, stall}, 0);
        tick();
        chk("held_valid", {31'b0, wb_valid_o}, 1);
        chk("held_data", wb_data_o, 32'h77);
        chk("held_dst", {26'b0, wb_dst_o}, 7);

        bundle(2'b10, 32'h200, 2'd0, 6'd9);
        Wdata = 32'hCAFE_F00D;
        tick();
        in_valid = 1'b0;
        chk("st_req", {31'b0, dmem_req}, 1);
        chk("st_we", {31'b0, dmem_we}, 1);
        chk("st_wdata", dmem_wdata, 32'hCAFE_F00D);
        chk("st_addr", dmem_addr, 32'h200);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("st_valid", {31'b0, wb_valid_o}, 1);
        chk("st_en", {31'b0, wb_en_o}, 0);
        chk("st_data", wb_data_o, 0);
        chk("st_fault", {31'b0, fault}, 0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_valid", {31'b0, wb_valid_o}, 0);

        bundle(2'b01, 32'h102, 2'd3, 6'd3);
        tick();
        chk("mis_req", {31'b0, dmem_req}, 0);
        chk("mis_valid", {31'b0, wb_valid_o}, 1);
        chk("mis_en", {31'b0, wb_en_o}, 0);
        chk("mis_fault", {31'b0, fault}, 1);
        chk("mis_stall", {31'b0, stall}, 0);
        bundle(2'b00, 32'h55, 2'd0, 6'd4);
        tick();
        chk("post_mis_data", wb_data_o, 32'h55);
        chk("post_mis_fault", {31'b0, fault}, 1);

        bundle(2'b01, 32'h300, 2'd3, 6'd6);
        tick();
        in_valid = 1'b0;
        chk("to_req0", {31'b0, dmem_req}, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("to_req%0d", i), {31'b0, dmem_req}, 1);
            chk($sformatf("to_valid%0d", i), {31'b0, wb_valid_o}, 0);
        end
        tick();
        chk("to_req_drop", {31'b0, dmem_req}, 0);
        chk("to_valid", {31'b0, wb_valid_o}, 1);
        chk("to_en", {31'b0, wb_en_o}, 0);
        chk("to_fault", {31'b0, fault}, 1);
        chk("to_stall", {31'b0, stall}, 0);
        bundle(2'b00, 32'h99, 2'd0, 6'd8);
        tick();
        in_valid = 1'b0;
        chk("resume_valid", {31'b0, wb_valid_o}, 1);
        chk("resume_data", wb_data_o, 32'h99);

        bundle(2'b01, 32'h400, 2'd3, 6'd10);
        tick();
        in_valid = 1'b0;
        chk("rsta_req", {31'b0, dmem_req}, 1);
        rst_n = 1'b0;
        tick();
        chk("rsta_req_drop", {31'b0, dmem_req}, 0);
        chk("rsta_stall", {31'b0, stall}, 0);
        chk("rsta_fault", {31'b0, fault}, 0);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, wb_valid_o}, 0);
        chk("late_ack_req", {31'b0, dmem_req}, 0);
        tick();
        chk("late_ack_valid2", {31'b0, wb_valid_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
